// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler: FSM states, default sizes and
// the index-width helper used by the arbiter and the top.
package counter_scheduler_pkg;

  localparam int unsigned N_REQ_DEF = 3;
  localparam int unsigned CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single requester still needs a one-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward with wrap-around.
module rr_pick
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[sel]) begin
        found    = 1'b1;
        win[sel] = 1'b1;
        win_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shared-counter scheduler: grants one requester at a time a run of len
// counting cycles, then pulses done; arbitration is round-robin.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_en,
  output logic [CNT_W-1:0]       count
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] win_len;
  logic             terminal;
  logic             owner_req;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_idx(win_idx)
  );

  // Terminal compare wraps at CNT_W bits, so len 0 runs the full 2^CNT_W cycles.
  always_comb begin
    win_len = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (32'(win_idx) == k) win_len = len[k*CNT_W +: CNT_W];
    end
    terminal  = (count == len_q - CNT_W'(1));
    owner_req = req[owner];
    ptr_next  = (32'(owner) == N_REQ - 1) ? '0 : owner + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      len_q  <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      cnt_en <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            state  <= RUN;
            owner  <= win_idx;
            len_q  <= win_len;
            gnt    <= win;
            busy   <= 1'b1;
            cnt_en <= 1'b1;
            count  <= '0;
          end
        end
        RUN: begin
          // Completion is checked before abort so a simultaneous drop still pulses done.
          if (terminal) begin
            state  <= DONE;
            done   <= gnt;
            gnt    <= '0;
            busy   <= 1'b0;
            cnt_en <= 1'b0;
            count  <= '0;
            ptr    <= ptr_next;
          end else if (!owner_req) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            cnt_en <= 1'b0;
            count  <= '0;
            ptr    <= ptr_next;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          done   <= '0;
          busy   <= 1'b0;
          cnt_en <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: directed runs push expected grant/end
// events; a negedge monitor pops and compares them and checks per-cycle invariants.
module tb_counter_scheduler;

  localparam int N = 3;
  localparam int W = 3;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] val;
    int           len;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] len = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           cnt_en;
  logic [W-1:0]   count;

  int total = 0;
  int bad = 0;
  ev_t sbq[$];

  int           run_len = 0;
  logic [N-1:0] prev_gnt = '0;

  counter_scheduler #(
    .N_REQ(N),
    .CNT_W(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .cnt_en(cnt_en),
    .count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [N-1:0] v, input int l);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.len  = l;
    sbq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input int v, input int budget);
    int  n = 0;
    logic hit = 1'b0;
    while (!hit && n < budget) begin
      cyc(1);
      n++;
      hit = (gnt != '0) && (32'(count) == v);
    end
    chk("wait_count", 32'(hit), 1);
  endtask

  task automatic wait_dones(input int want, input int budget);
    int n = 0;
    int seen = 0;
    while (seen < want && n < budget) begin
      cyc(1);
      n++;
      if (done != '0) seen++;
    end
    chk("wait_done", seen, want);
  endtask

  // Monitor: grant rise pops a GRANT event, grant fall pops DONE or ABORT with run length.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      run_len  = 0;
      prev_gnt = '0;
    end else begin
      chk("gnt_onehot", 32'($onehot0(gnt)), 1);
      chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
      if (gnt != '0) begin
        chk("done_with_gnt", 32'(done), 0);
        if (prev_gnt == '0) begin
          run_len = 0;
          if (sbq.size() == 0) begin
            chk("sb_grant_unexpected", 32'(gnt), 0);
          end else begin
            e = sbq.pop_front();
            chk("ev_kind_grant", EV_GRANT, e.kind);
            chk("grant_val", 32'(gnt), 32'(e.val));
          end
        end
        chk("run_count", 32'(count), 32'(run_len % (1 << W)));
        chk("run_cnt_en", 32'(cnt_en), 1);
        run_len++;
      end else begin
        chk("idle_count", 32'(count), 0);
        chk("idle_cnt_en", 32'(cnt_en), 0);
        if (prev_gnt != '0) begin
          if (sbq.size() == 0) begin
            chk("sb_end_unexpected", 32'(done), 0);
          end else begin
            e = sbq.pop_front();
            chk("ev_kind_end", (done != '0) ? EV_DONE : EV_ABORT, e.kind);
            chk("end_val", (done != '0) ? 32'(done) : 32'(prev_gnt), 32'(e.val));
            chk("run_len", run_len, e.len);
          end
        end else begin
          chk("stray_done", 32'(done), 0);
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_count", 32'(count), 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    // Single run, len 3: three counting cycles then done.
    push(EV_GRANT, 3'b001, 0);
    push(EV_DONE, 3'b001, 3);
    len = {3'd0, 3'd0, 3'd3};
    req = 3'b001;
    cyc(1);
    chk("grant_latency", 32'(gnt), 32'(3'b001));
    wait_dones(1, 20);
    req = '0;
    cyc(3);

    // len 0 wraps to a full 8-cycle run.
    push(EV_GRANT, 3'b010, 0);
    push(EV_DONE, 3'b010, 8);
    len = {3'd0, 3'd0, 3'd0};
    req = 3'b010;
    wait_dones(1, 20);
    req = '0;
    cyc(3);

    // Abort at count 2: back to idle with no done pulse.
    push(EV_GRANT, 3'b100, 0);
    push(EV_ABORT, 3'b100, 3);
    len = {3'd5, 3'd0, 3'd0};
    req = 3'b100;
    wait_count(2, 20);
    req = '0;
    cyc(1);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_done", 32'(done), 0);
    cyc(2);
    chk("abort_no_late_done", 32'(done), 0);

    // Fairness from ptr 0 with all requesting, len 1 each.
    push(EV_GRANT, 3'b001, 0);
    push(EV_DONE, 3'b001, 1);
    push(EV_GRANT, 3'b010, 0);
    push(EV_DONE, 3'b010, 1);
    push(EV_GRANT, 3'b100, 0);
    push(EV_DONE, 3'b100, 1);
    push(EV_GRANT, 3'b001, 0);
    push(EV_DONE, 3'b001, 1);
    len = {3'd1, 3'd1, 3'd1};
    req = 3'b111;
    wait_dones(4, 40);
    req = '0;
    cyc(3);

    // Abort and terminal count in the same cycle: completion wins.
    push(EV_GRANT, 3'b001, 0);
    push(EV_DONE, 3'b001, 2);
    len = {3'd0, 3'd0, 3'd2};
    req = 3'b001;
    wait_count(1, 20);
    req = '0;
    cyc(1);
    chk("simul_done", 32'(done), 32'(3'b001));
    cyc(3);

    // Reset mid-run, then arbitration restarts at requester 0.
    push(EV_GRANT, 3'b100, 0);
    len = {3'd0, 3'd0, 3'd0};
    req = 3'b100;
    wait_count(3, 20);
    reset = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt_en", 32'(cnt_en), 0);
    chk("midrst_count", 32'(count), 0);
    push(EV_GRANT, 3'b001, 0);
    push(EV_DONE, 3'b001, 2);
    push(EV_GRANT, 3'b010, 0);
    push(EV_DONE, 3'b010, 1);
    len = {3'd0, 3'd1, 3'd2};
    req = 3'b011;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_first_gnt", 32'(gnt), 32'(3'b001));
    wait_dones(2, 30);
    req = '0;
    cyc(4);

    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the counter.
REQ-002 Parameter CNT_W, default 3: counter width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; reset input 1, asynchronous active-low reset.
REQ-004 req  input  N_REQ: per-requester request level, held high until done or abandoned.
REQ-005 len  input  N_REQ*CNT_W: packed per-requester run length; slice i = len[i*CNT_W +: CNT_W].
REQ-006 gnt  output  N_REQ: one-hot grant, high for the owner while it runs.
REQ-007 done  output  N_REQ: one-cycle completion pulse to the owner.
REQ-008 busy  output  1: high while any grant is active.
REQ-009 cnt_en  output  1: count-enable (T input) of the shared counter, high on every counting cycle.
REQ-010 count  output  CNT_W: current shared count value.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-012 IDLE: if any req bit is high, the block SHALL pick a winner by round-robin from pointer ptr, latch len[winner] into len_q, and enter RUN; otherwise it SHALL stay in IDLE.
REQ-013 Grant latency SHALL be one cycle: req sampled high in IDLE at edge t gives gnt high after edge t+1.
REQ-014 RUN: gnt[winner]=1, busy=1, cnt_en=1; count SHALL start at 0 and increment by 1 each cycle.
REQ-015 Run length arithmetic SHALL be modulo 2^CNT_W: the run ends on the cycle where count == len_q-1 (mod 2^CNT_W); len=0 therefore means 2^CNT_W cycles (8 for the defaults).
REQ-016 On the terminal count the FSM SHALL enter DONE; in DONE: done[winner]=1 for exactly one cycle, gnt=0, cnt_en=0, count=0, busy=0; it then returns to IDLE.
REQ-017 If req[winner] drops during RUN (abort), the next state SHALL be IDLE with gnt=0, count=0, cnt_en=0 and no done pulse.
REQ-018 If an abort and the terminal count occur in the same cycle, completion SHALL win: DONE is entered and done pulses.
REQ-019 After a completion or abort by requester i, ptr SHALL become (i+1) mod N_REQ; ptr SHALL hold otherwise.
REQ-020 The arbiter SHALL not re-arbitrate in DONE; new requests are evaluated only in IDLE, so back-to-back runs are separated by a DONE cycle and an IDLE cycle.
REQ-021 Changes to len for the owner during RUN SHALL have no effect; only len_q is used.
REQ-022 gnt SHALL never have more than one bit set, and done SHALL never be set while gnt is set.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force: state=IDLE, ptr=0, gnt=0, done=0, busy=0, cnt_en=0, count=0, len_q=0.
REQ-024 A reset asserted mid-RUN SHALL abandon the run with no done pulse; after reset release, arbitration SHALL restart with requester 0 at highest priority.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the defaults for N_REQ and CNT_W.
REQ-026 The round-robin selection SHALL be a separate combinational sub-module, rr_pick (inputs req and ptr; output a one-hot winner plus its index).
REQ-027 The count register SHALL be internal to this block and exported on count; no external counter feedback SHALL be required.

Verification
REQ-028 Single run: req=001, len[0]=3 -> gnt=001 from cycle 1; count 0,1,2 with cnt_en=1; done=001 on cycle 4; busy low on cycle 4.
REQ-029 Full wrap: req=010, len[1]=0 -> 8 RUN cycles with count 0..7, then done=010.
REQ-030 Fairness: req=111 held, every len=1 -> grant order 0,1,2,0; each done pulse one cycle wide; gnt always one-hot.
REQ-031 Abort: req=100, len[2]=5; drop req[2] when count=2 -> IDLE next cycle, count=0, no done pulse, ptr=0.
REQ-032 Simultaneous events: requester 0 drops req at the terminal count (len=2, count=1) -> DONE entered and done=001.
REQ-033 Reset mid-run: assert reset at count=3 -> all outputs 0 immediately; after release with req=011 -> gnt=001 first.
